// File: rtl/qspi_arb_pkg.sv
// qspi_arb_pkg: shared FSM states, word geometry, default address width and grant-index width helper for qspi_read_arbiter
package qspi_arb_pkg;
  typedef enum logic [1:0] {IDLE, STREAM, GAP} state_t;
  localparam int BYTES_PER_WORD = 4;
  localparam int DEF_ADDR_W = 24;
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/qspi_read_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick; req/ptr in, one-hot gnt, binary idx and any out, search starts at ptr
module rr_arbiter #(
  parameter int N = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % N]) begin
        gnt = '0;
        gnt[(int'(ptr) + k) % N] = 1'b1;
        idx = IW'((int'(ptr) + k) % N);
        any = 1'b1;
      end
    end
  end
endmodule

// File: rtl/qspi_read_arbiter.sv
// qspi_read_arbiter: round-robin share of the QSPI byte reader among NUM_REQ word readers (req_valid/req_addr in, rsp_valid/rsp_data/busy out, flash_addr/flash_do_read to reader, flash_setup_done/flash_data_ready/flash_data from reader); QSPI_ARB_STREAM_EN enables sequential streaming without a GAP
module qspi_read_arbiter
  import qspi_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [31:0]               rsp_data,
  output logic                      busy,
  output logic [ADDR_W-1:0]         flash_addr,
  output logic                      flash_do_read,
  input  logic                      flash_setup_done,
  input  logic                      flash_data_ready,
  input  logic [7:0]                flash_data
);
  localparam int IW = idx_w(NUM_REQ);
  state_t state, state_n;
  logic [IW-1:0] grant, rr, nxt_rr, arb_idx, arb_ptr;
  logic [NUM_REQ-1:0] grant_oh, arb_req, arb_gnt;
  logic arb_any, done, cont, take;
  logic [1:0] cnt;
  logic [23:0] word;
  logic [ADDR_W-1:0] arb_addr;
  rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_rr (
    .req(arb_req),
    .ptr(arb_ptr),
    .gnt(arb_gnt),
    .idx(arb_idx),
    .any(arb_any)
  );
  assign arb_addr = req_addr[int'(arb_idx)*ADDR_W +: ADDR_W];
  assign nxt_rr = (grant == IW'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
  assign done = state == STREAM && flash_setup_done && flash_data_ready && cnt == 2'd3;
  assign busy = state != IDLE;
`ifdef QSPI_ARB_STREAM_EN
  logic [ADDR_W-1:0] stream_ptr;
  logic [NUM_REQ-1:0] others;
  assign stream_ptr = flash_addr + ADDR_W'(BYTES_PER_WORD);
  assign others = req_valid & ~grant_oh;
  assign arb_req = state == STREAM ? (|others ? others : req_valid & grant_oh) : req_valid;
  assign arb_ptr = state == STREAM ? nxt_rr : rr;
  assign cont = done && arb_any && arb_addr == stream_ptr;
`else
  assign arb_req = req_valid;
  assign arb_ptr = rr;
  assign cont = 1'b0;
`endif
  always_comb begin
    state_n = state == IDLE   ? (flash_setup_done && arb_any ? STREAM : IDLE)
            : state == STREAM ? (!flash_setup_done || (done && !cont) ? GAP : STREAM)
            : IDLE;
    take = (state == IDLE && state_n == STREAM) || cont;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      grant <= '0;
      grant_oh <= '0;
      rr <= '0;
      cnt <= '0;
      word <= '0;
      rsp_valid <= '0;
      rsp_data <= '0;
      flash_addr <= '0;
      flash_do_read <= 1'b0;
    end else begin
      state <= state_n;
      flash_do_read <= state_n == STREAM;
      rsp_valid <= '0;
      if (state == STREAM && flash_setup_done && flash_data_ready) begin
        word <= {flash_data, word[23:8]};
        cnt <= cnt + 2'd1;
      end
      if (done) begin
        rsp_valid <= grant_oh;
        rsp_data <= {flash_data, word};
        rr <= nxt_rr;
      end
      if (take) begin
        grant <= arb_idx;
        grant_oh <= arb_gnt;
        flash_addr <= arb_addr;
        cnt <= '0;
      end
    end
  end
endmodule
